// File: rtl/nest_keyword_checker.sv
// Streaming nested-keyword checker: recognises begin/end (and optionally fork/join) as whole words,
// keeps a type stack of open blocks and reports balance, depth and the first structural error.
module nest_keyword_checker #(
  parameter int MAX_DEPTH = 16,
  parameter int DEPTH_W   = 5,
  parameter int CASE_SENS = 0,
  parameter int EN_FORK   = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [7:0]         in,
  output logic               result,
  output logic [DEPTH_W-1:0] depth,
  output logic               error,
  output logic [1:0]         err_code
);

  // Handshake: a character is consumed on every posedge where in_valid is high; there is no
  // back-pressure, and in_valid low holds every register.

  typedef enum logic [4:0] {
    S_IDLE, S_B1, S_B2, S_B3, S_B4, S_BN,
    S_E1, S_E2, S_ED,
    S_F1, S_F2, S_F3, S_FK,
    S_J1, S_J2, S_J3, S_JN,
    S_OTHER
  } word_state_t;

  localparam logic [1:0] ERR_NONE      = 2'b00;
  localparam logic [1:0] ERR_UNDERFLOW = 2'b01;
  localparam logic [1:0] ERR_MISMATCH  = 2'b10;
  localparam logic [1:0] ERR_OVERFLOW  = 2'b11;

  word_state_t          state_q, state_d;
  logic [DEPTH_W-1:0]   depth_q, depth_d;
  logic [MAX_DEPTH-1:0] stack_q, stack_d;
  logic                 error_q, error_d;
  logic [1:0]           code_q, code_d;
  logic                 is_sep, top_type, at_max, at_zero, result_c;

  function automatic logic ch_is(input logic [7:0] c, input logic [7:0] lc);
    logic letter;
    letter = ((c >= 8'h41) && (c <= 8'h5A)) || ((c >= 8'h61) && (c <= 8'h7A));
    if ((CASE_SENS == 0) && letter) return (c | 8'h20) == lc;
    return c == lc;
  endfunction

  assign is_sep  = (in == 8'h20) || (in == 8'h09) || (in == 8'h0A) || (in == 8'h0D);
  assign at_max  = (depth_q == DEPTH_W'(MAX_DEPTH));
  assign at_zero = (depth_q == '0);

  // Top of stack lives at index depth-1; type 1 means fork.
  always_comb begin
    top_type = 1'b0;
    for (int i = 0; i < MAX_DEPTH; i++) begin
      if (DEPTH_W'(i + 1) == depth_q) top_type = stack_q[i];
    end
  end

  always_comb begin
    state_d = state_q;
    depth_d = depth_q;
    stack_d = stack_q;
    error_d = error_q;
    code_d  = code_q;
    if (in_valid) begin
      if (is_sep) begin
        state_d = S_IDLE;
        if (!error_q) begin
          case (state_q)
            S_BN, S_FK: begin
              if (at_max) begin
                error_d = 1'b1;
                code_d  = ERR_OVERFLOW;
              end else begin
                for (int i = 0; i < MAX_DEPTH; i++) begin
                  if (DEPTH_W'(i) == depth_q) stack_d[i] = (state_q == S_FK);
                end
                depth_d = depth_q + 1'b1;
              end
            end
            S_ED, S_JN: begin
              if (at_zero) begin
                error_d = 1'b1;
                code_d  = ERR_UNDERFLOW;
              end else if (top_type != (state_q == S_JN)) begin
                error_d = 1'b1;
                code_d  = ERR_MISMATCH;
              end else begin
                depth_d = depth_q - 1'b1;
              end
            end
            default: ;
          endcase
        end
      end else begin
        state_d = S_OTHER;
        case (state_q)
          S_IDLE: begin
            if (ch_is(in, 8'h62))                       state_d = S_B1;
            else if (ch_is(in, 8'h65))                  state_d = S_E1;
            else if ((EN_FORK != 0) && ch_is(in, 8'h66)) state_d = S_F1;
            else if ((EN_FORK != 0) && ch_is(in, 8'h6A)) state_d = S_J1;
          end
          S_B1: if (ch_is(in, 8'h65)) state_d = S_B2;
          S_B2: if (ch_is(in, 8'h67)) state_d = S_B3;
          S_B3: if (ch_is(in, 8'h69)) state_d = S_B4;
          S_B4: if (ch_is(in, 8'h6E)) state_d = S_BN;
          S_E1: if (ch_is(in, 8'h6E)) state_d = S_E2;
          S_E2: if (ch_is(in, 8'h64)) state_d = S_ED;
          S_F1: if (ch_is(in, 8'h6F)) state_d = S_F2;
          S_F2: if (ch_is(in, 8'h72)) state_d = S_F3;
          S_F3: if (ch_is(in, 8'h6B)) state_d = S_FK;
          S_J1: if (ch_is(in, 8'h6F)) state_d = S_J2;
          S_J2: if (ch_is(in, 8'h69)) state_d = S_J3;
          S_J3: if (ch_is(in, 8'h6E)) state_d = S_JN;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      depth_q <= '0;
      stack_q <= '0;
      error_q <= 1'b0;
      code_q  <= ERR_NONE;
    end else begin
      state_q <= state_d;
      depth_q <= depth_d;
      stack_q <= stack_d;
      error_q <= error_d;
      code_q  <= code_d;
    end
  end

  // A completed keyword still waiting for its separator is folded into the balance.
  always_comb begin
    result_c = 1'b0;
    if (!error_q) begin
      case (state_q)
        S_BN, S_FK: result_c = 1'b0;
        S_ED, S_JN: result_c = (depth_q == DEPTH_W'(1)) && (top_type == (state_q == S_JN));
        default:    result_c = at_zero;
      endcase
    end
  end

  assign result   = result_c;
  assign depth    = depth_q;
  assign error    = error_q;
  assign err_code = code_q;

endmodule

// File: tb/tb_nest_keyword_checker.sv
// Directed bench for nest_keyword_checker: a table of per-character expectations for the default
// configuration, plus hand-written sequences for a shallow stack and case-sensitive/no-fork variants.
module tb_nest_keyword_checker;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_ch = 8'h20;

  logic       result, error;
  logic [4:0] depth;
  logic [1:0] err_code;
  logic       d4_result, d4_error;
  logic [2:0] d4_depth;
  logic [1:0] d4_err_code;
  logic       cs_result, cs_error;
  logic [4:0] cs_depth;
  logic [1:0] cs_err_code;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  nest_keyword_checker dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in(in_ch),
    .result(result), .depth(depth), .error(error), .err_code(err_code)
  );

  nest_keyword_checker #(.MAX_DEPTH(4), .DEPTH_W(3)) dut_d4 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in(in_ch),
    .result(d4_result), .depth(d4_depth), .error(d4_error), .err_code(d4_err_code)
  );

  nest_keyword_checker #(.CASE_SENS(1), .EN_FORK(0)) dut_cs (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in(in_ch),
    .result(cs_result), .depth(cs_depth), .error(cs_error), .err_code(cs_err_code)
  );

  typedef struct {
    logic       rst;
    logic       v;
    logic [7:0] ch;
    logic       r;
    logic [4:0] d;
    logic [1:0] c;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic add_seq(input string s, input string r, input string d, input string c);
    for (int i = 0; i < s.len(); i++) begin
      vec_t t;
      t.rst = 1'b0;
      t.v   = 1'b1;
      t.ch  = s[i];
      t.r   = (r[i] == 8'h31);
      t.d   = 5'(d[i] - 8'h30);
      t.c   = 2'(c[i] - 8'h30);
      vecs.push_back(t);
    end
  endtask

  task automatic add_idle(input int n, input logic r, input logic [4:0] d, input logic [1:0] c);
    for (int i = 0; i < n; i++) begin
      vec_t t;
      t.rst = 1'b0; t.v = 1'b0; t.ch = 8'h69; t.r = r; t.d = d; t.c = c;
      vecs.push_back(t);
    end
  endtask

  task automatic add_rst();
    vec_t t;
    t.rst = 1'b1; t.v = 1'b0; t.ch = 8'h20; t.r = 1'b1; t.d = 5'd0; t.c = 2'd0;
    vecs.push_back(t);
  endtask

  task automatic drive(input logic v, input logic [7:0] ch);
    @(negedge clk);
    in_valid = v;
    in_ch    = ch;
    @(posedge clk);
    #1;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) drive(1'b1, s[i]);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid = 1'b0;
    reset    = 1'b1;
    @(negedge clk);
    reset    = 1'b0;
  endtask

  initial begin
    add_rst();
    add_seq("begin  end ",  "11110000011", "00000111110", "00000000000");
    add_seq("begin\tend\n", "1111000011",  "0000011110",  "0000000000");
    add_seq("fork join ",   "1110000011",  "0000111110",  "0000000000");
    add_rst();
    add_seq("end begin end ", "11000000000000", "00000000000000", "00011111111111");
    add_rst();
    add_seq("begin fork end ", "111100000000000", "000001111122222", "000000000000002");
    add_rst();
    add_seq("beginx endy begi ", "11110111101111111", "00000000000000000", "00000000000000000");
    add_seq("BeGiN ", "111100", "000001", "000000");
    add_rst();
    add_seq("beg", "111", "000", "000");
    add_idle(3, 1'b1, 5'd0, 2'd0);
    add_seq("in ", "100", "001", "000");
    add_seq("beg", "000", "111", "000");
    add_rst();

    for (int k = 0; k < vecs.size(); k++) begin
      if (vecs[k].rst) begin
        @(negedge clk);
        in_valid = 1'b0;
        reset    = 1'b1;
        #2;
      end else begin
        drive(vecs[k].v, vecs[k].ch);
      end
      check($sformatf("vec%0d result", k),   32'(result),   32'(vecs[k].r));
      check($sformatf("vec%0d depth", k),    32'(depth),    32'(vecs[k].d));
      check($sformatf("vec%0d error", k),    32'(error),    32'(vecs[k].c != 2'd0));
      check($sformatf("vec%0d err_code", k), 32'(err_code), 32'(vecs[k].c));
      if (vecs[k].rst) begin
        @(negedge clk);
        reset = 1'b0;
      end
    end

    // Overflow on a four-deep stack, then proof that the error is sticky.
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      send_str("begin ");
      check($sformatf("d4 depth after begin %0d", k), 32'(d4_depth), (k <= 4) ? k : 4);
      check($sformatf("d4 err_code after begin %0d", k), 32'(d4_err_code), (k == 5) ? 3 : 0);
    end
    send_str("end end ");
    check("d4 sticky err_code", 32'(d4_err_code), 32'd3);
    check("d4 frozen depth",    32'(d4_depth),    32'd4);
    check("d4 sticky error",    32'(d4_error),    32'd1);
    check("d4 result",          32'(d4_result),   32'd0);

    // Case-sensitive, fork/join disabled.
    do_reset();
    send_str("BeGiN ");
    check("cs mixed-case depth",  32'(cs_depth),  32'd0);
    check("cs mixed-case result", 32'(cs_result), 32'd1);
    send_str("begin ");
    check("cs begin depth", 32'(cs_depth), 32'd1);
    send_str("fork join ");
    check("cs fork/join depth",    32'(cs_depth),    32'd1);
    check("cs fork/join err_code", 32'(cs_err_code), 32'd0);
    send_str("end ");
    check("cs end depth",    32'(cs_depth),    32'd0);
    check("cs end result",   32'(cs_result),   32'd1);
    check("cs end err_code", 32'(cs_err_code), 32'd0);
    check("cs end error",    32'(cs_error),    32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
